// File: rtl/ets_sweep_controller_if.sv
// Bundle of sweep control, configuration and capture-handshake signals
// shared between the ETS sweep controller and its host/sampler.
// The master modport is the controller's view; slave is the host/sampler side.
interface ets_sweep_controller_if;
  logic       start;
  logic       abort;
  logic [7:0] delay_start;
  logic [7:0] delay_step;
  logic [7:0] num_points;
  logic [7:0] delay;
  logic       cap_req;
  logic       cap_ack;
  logic       busy;
  logic       done;
  logic [7:0] point_idx;

  modport master (
    input  start, abort, delay_start, delay_step, num_points, cap_ack,
    output delay, cap_req, busy, done, point_idx
  );

  modport slave (
    output start, abort, delay_start, delay_step, num_points, cap_ack,
    input  delay, cap_req, busy, done, point_idx
  );
endinterface

// File: rtl/ets_sweep_controller.sv
// ETS sweep controller: steps the sampling-clock phase code through a
// configured sequence, waits for the delay line to settle after each update,
// then requests one capture per point from the sampler.
module ets_sweep_controller #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ets_sweep_controller_if.master bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       delay_q, delay_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       step_q, step_d;
  logic [7:0]       num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_req_q;
  logic             busy_q;
  logic             done_q;

  // Next-state and next-datapath logic; the configuration is captured once at
  // start so mid-sweep input changes cannot disturb the running sweep.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    idx_d   = idx_q;
    step_d  = step_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          step_d  = bus.delay_step;
          num_d   = bus.num_points;
          delay_d = bus.delay_start;
          idx_d   = 8'd0;
          cnt_d   = '0;
          state_d = (bus.num_points != 8'd0) ? SETTLE : DONE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.cap_ack) begin
          if (idx_q == num_q - 8'd1) begin
            state_d = DONE;
          end else begin
            delay_d = delay_q + step_q;
            idx_d   = idx_q + 8'd1;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; status outputs are decoded from the next
  // state so they line up with the state they describe without any
  // combinational path from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      delay_q   <= 8'd0;
      idx_q     <= 8'd0;
      step_q    <= 8'd0;
      num_q     <= 8'd0;
      cnt_q     <= '0;
      cap_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      cap_req_q <= (state_d == CAPTURE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.delay     = delay_q;
  assign bus.point_idx = idx_q;
  assign bus.cap_req   = cap_req_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ets_sweep_controller.sv
// Self-checking bench for ets_sweep_controller: table of directed sweeps,
// hand-written abort and reset sequences, and randomized sweeps checked
// against a point-list model (delay of point i = start + i*step mod 256).
module tb_ets_sweep_controller;

  localparam int SETTLE = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  // Free-running clock
  always #5 clk = ~clk;

  ets_sweep_controller_if bus ();

  ets_sweep_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Count done pulses independently of the sequences that expect them
  always @(posedge clk) begin
    if (bus.done) done_count++;
  end

  // Hard stop in case something wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0] ds;
    logic [7:0] st;
    logic [7:0] n;
    int         ack_lat;
    bit         scramble;
    logic [7:0] exp_delay;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t vecs[6];

  task automatic applyStimulus(input logic s, input logic a, input logic [7:0] ds,
                               input logic [7:0] st, input logic [7:0] n,
                               input logic ack);
    bus.start       = s;
    bus.abort       = a;
    bus.delay_start = ds;
    bus.delay_step  = st;
    bus.num_points  = n;
    bus.cap_ack     = ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // While a sweep runs, either keep inputs quiet or throw random junk at
  // start/config (which must be ignored); abort always stays low here.
  task automatic driveBusy(input bit scramble, input logic ack);
    if (scramble)
      applyStimulus(1'($urandom), 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), ack);
    else begin
      bus.start   = 1'b0;
      bus.cap_ack = ack;
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Launch a sweep from IDLE (called at a negedge) and follow it point by
  // point to the first IDLE cycle afterwards.
  task automatic run_sweep(input logic [7:0] ds, input logic [7:0] st, input logic [7:0] n,
                           input int ack_lat, input bit scramble);
    logic [7:0] exp_d;
    int         cnt;
    int         d0;
    d0 = done_count;
    exp_d = ds;
    applyStimulus(1'b1, 1'b0, ds, st, n, 1'b0);
    @(negedge clk);
    if (scramble) applyStimulus(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    else bus.start = 1'b0;
    if (n == 8'd0) begin
      checkOutput("zero_busy", bus.busy, 1);
      checkOutput("zero_done", bus.done, 1);
      checkOutput("zero_capreq", bus.cap_req, 0);
      checkOutput("zero_delay", bus.delay, ds);
      checkOutput("zero_idx", bus.point_idx, 0);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("zero_busy_end", bus.busy, 0);
      checkOutput("zero_done_end", bus.done, 0);
      checkOutput("zero_capreq_end", bus.cap_req, 0);
      checkOutput("zero_done_count", done_count - d0, 1);
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_d = 8'(int'(ds) + i * int'(st));
      checkOutput($sformatf("pt%0d_delay", i), bus.delay, exp_d);
      checkOutput($sformatf("pt%0d_idx", i), bus.point_idx, i);
      checkOutput($sformatf("pt%0d_req_low", i), bus.cap_req, 0);
      checkOutput($sformatf("pt%0d_busy", i), bus.busy, 1);
      cnt = 0;
      while (!bus.cap_req && cnt <= SETTLE + 4) begin
        driveBusy(scramble, scramble ? 1'($urandom) : 1'b0);
        @(negedge clk);
        cnt++;
      end
      checkOutput($sformatf("pt%0d_settle_len", i), cnt, SETTLE);
      if (!bus.cap_req) begin
        applyStimulus(1'b0, 1'b0, ds, st, n, 1'b0);
        return;
      end
      checkOutput($sformatf("pt%0d_delay_held", i), bus.delay, exp_d);
      for (int k = 0; k < ack_lat; k++) begin
        driveBusy(scramble, 1'b0);
        @(negedge clk);
        checkOutput($sformatf("pt%0d_req_held", i), bus.cap_req, 1);
      end
      driveBusy(scramble, 1'b1);
      @(negedge clk);
      bus.cap_ack = 1'b0;
      checkOutput($sformatf("pt%0d_req_drop", i), bus.cap_req, 0);
    end
    bus.start = 1'b0;
    checkOutput("end_done", bus.done, 1);
    checkOutput("end_busy", bus.busy, 1);
    checkOutput("end_delay", bus.delay, exp_d);
    checkOutput("end_idx", bus.point_idx, n - 8'd1);
    @(negedge clk);
    checkOutput("idle_done", bus.done, 0);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_capreq", bus.cap_req, 0);
    checkOutput("idle_delay", bus.delay, exp_d);
    checkOutput("done_count", done_count - d0, 1);
  endtask

  // Abort during CAPTURE of point 1 of 4 with a simultaneous ack and start
  task automatic abort_test();
    int d0;
    bit found;
    d0 = done_count;
    found = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h40, 8'h10, 8'd4, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.point_idx == 8'd1 && bus.cap_req) begin
        found = 1'b1;
        break;
      end
      bus.cap_ack = bus.cap_req;
      @(negedge clk);
    end
    checkOutput("abort_reach_capture", found, 1);
    applyStimulus(1'b1, 1'b1, 8'h40, 8'h10, 8'd4, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h40, 8'h10, 8'd4, 1'b0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_capreq", bus.cap_req, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_idx", bus.point_idx, 1);
    checkOutput("abort_delay", bus.delay, 8'h50);
    @(negedge clk);
    checkOutput("abort_still_idle", bus.busy, 0);
    checkOutput("abort_delay_hold", bus.delay, 8'h50);
    checkOutput("abort_no_done", done_count - d0, 0);
  endtask

  // Asynchronous reset during SETTLE of point 2, then a fresh sweep
  task automatic reset_test();
    int d0;
    bit found;
    d0 = done_count;
    found = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h30, 8'h02, 8'd4, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.point_idx == 8'd2 && !bus.cap_req && bus.busy) begin
        found = 1'b1;
        break;
      end
      bus.cap_ack = bus.cap_req;
      @(negedge clk);
    end
    bus.cap_ack = 1'b0;
    checkOutput("rst_reach_pt2", found, 1);
    checkOutput("rst_pt2_delay", bus.delay, 8'h34);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_delay", bus.delay, 0);
    checkOutput("rst_async_capreq", bus.cap_req, 0);
    checkOutput("rst_async_busy", bus.busy, 0);
    checkOutput("rst_async_done", bus.done, 0);
    checkOutput("rst_async_idx", bus.point_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_done", done_count - d0, 0);
    run_sweep(8'h30, 8'h02, 8'd2, 0, 1'b0);
    checkOutput("rst_fresh_delay", bus.delay, 8'h32);
    checkOutput("rst_fresh_idx", bus.point_idx, 8'd1);
  endtask

  initial begin
    logic [7:0] rds, rst, rn;
    vecs[0] = '{8'h10, 8'h04, 8'd3, 2, 1'b0, 8'h18, 8'd2};
    vecs[1] = '{8'hFC, 8'h08, 8'd2, 1, 1'b0, 8'h04, 8'd1};
    vecs[2] = '{8'h55, 8'h07, 8'd0, 0, 1'b0, 8'h55, 8'd0};
    vecs[3] = '{8'h20, 8'h00, 8'd4, 1, 1'b1, 8'h20, 8'd3};
    vecs[4] = '{8'h80, 8'h40, 8'd5, 3, 1'b1, 8'h80, 8'd4};
    vecs[5] = '{8'hF0, 8'h11, 8'd1, 0, 1'b1, 8'hF0, 8'd0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    #1;
    checkOutput("reset_delay", bus.delay, 0);
    checkOutput("reset_capreq", bus.cap_req, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_idx", bus.point_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      $display("[TB] vector %0d: start=0x%0h step=0x%0h points=%0d", v, vecs[v].ds, vecs[v].st, vecs[v].n);
      run_sweep(vecs[v].ds, vecs[v].st, vecs[v].n, vecs[v].ack_lat, vecs[v].scramble);
      checkOutput($sformatf("vec%0d_final_delay", v), bus.delay, vecs[v].exp_delay);
      checkOutput($sformatf("vec%0d_final_idx", v), bus.point_idx, vecs[v].exp_idx);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("vec%0d_idle_hold", v), bus.delay, vecs[v].exp_delay);
    end

    do_reset();
    abort_test();
    do_reset();
    reset_test();
    do_reset();

    for (int r = 0; r < 8; r++) begin
      rds = 8'($urandom);
      rst = 8'($urandom);
      rn  = 8'($urandom_range(0, 5));
      $display("[TB] random sweep %0d: start=0x%0h step=0x%0h points=%0d", r, rds, rst, rn);
      run_sweep(rds, rst, rn, int'($urandom_range(0, 3)), 1'b1);
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
